el2_dec_gpr_wb_arb: RTL

GPR writeback arbiter feeding the two write ports of the decode-stage general-purpose register file. It passes in-order pipeline writebacks straight to write port 0 and buffers late, out-of-order results (non-blocking load returns, divider results) in a small queue drained onto write port 1. It guarantees that the two ports never target the same register in one cycle. It cancels queued results that a younger in-order write has superseded.

---
 rtl/el2_dec_gpr_wb_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/el2_dec_gpr_wb_arb.sv
`default_nettype none
// el2_dec_gpr_wb_arb: GPR writeback arbiter, port 0 in-order, port 1 drains a late-writeback queue.
// Optional RV_GPR_WB_BYPASS_EN lets a secondary write skip an empty queue. Revision 1.0
module el2_dec_gpr_wb_arb #(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     p_wen,
  input  logic [4:0]               p_waddr,
  input  logic [31:0]              p_wd,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [4:0]               s_waddr,
  input  logic [31:0]              s_wd,
  input  logic                     flush,
  output logic                     wen0,
  output logic [4:0]               waddr0,
  output logic [31:0]              wd0,
  output logic                     wen1,
  output logic [4:0]               waddr1,
  output logic [31:0]              wd1,
  output logic [31:1]              gpr_pend,
  output logic [$clog2(QDEPTH):0]  q_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [4:0]        addr_q [QDEPTH];
  logic [31:0]       data_q [QDEPTH];
  logic [QDEPTH-1:0] live_q;
  logic [QDEPTH-1:0] live_nxt;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;

  logic        empty;
  logic        head_live;
  logic        head_sup;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        pop;
  logic        push;
  logic        q_wen;
  logic        s_conflict;
  logic        s_live;
  logic        bypass;

  assign wen0   = p_wen & (p_waddr != 5'd0);
  assign waddr0 = p_waddr;
  assign wd0    = p_wd;

  assign empty     = (cnt == '0);
  assign s_ready   = (cnt < CW'(QDEPTH));
  assign q_cnt     = cnt;
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_live = live_q[rd_ptr];

  // A same-cycle primary write to the head's register is younger, so the head dies silently.
  assign head_sup   = p_wen & (p_waddr == head_addr);
  assign pop        = ~empty & ~flush;
  assign q_wen      = pop & head_live & ~head_sup;
  assign s_conflict = p_wen & (p_waddr == s_waddr);
  assign s_live     = (s_waddr != 5'd0) & ~s_conflict;

`ifdef RV_GPR_WB_BYPASS_EN
  assign bypass = empty & s_valid & (s_waddr != 5'd0) & ~flush & ~s_conflict;
`else
  assign bypass = 1'b0;
`endif

  assign push = s_valid & s_ready & ~flush & ~bypass;
  assign wen1 = q_wen | bypass;

  always_comb begin
    waddr1 = 5'd0;
    wd1    = 32'd0;
    if (bypass) begin
      waddr1 = s_waddr;
      wd1    = s_wd;
    end else if (q_wen) begin
      waddr1 = head_addr;
      wd1    = head_data;
    end
  end

  always_comb begin
    live_nxt = live_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (p_wen && (addr_q[i] == p_waddr)) live_nxt[i] = 1'b0;
    end
    if (pop)  live_nxt[rd_ptr] = 1'b0;
    if (push) live_nxt[wr_ptr] = s_live;
  end

  always_comb begin
    gpr_pend = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      for (int j = 1; j < 32; j++) begin
        if (live_q[i] && (addr_q[i] == 5'(j))) gpr_pend[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      live_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      live_q <= '0;
    end else begin
      live_q <= live_nxt;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push) begin
        addr_q[wr_ptr] <= s_waddr;
        data_q[wr_ptr] <= s_wd;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

endmodule
`default_nettype wire
